// File: rtl/bdd_pkg.sv
// Shared types, widths and node/child word field extractors for the
// decision-diagram traversal engine. This package is the configuration point.
package bdd_pkg;

    localparam int N_ATTR    = 4;
    localparam int ATTR_W    = 8;
    localparam int COEFF_W   = 6;
    localparam int THR_W     = 10;
    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 32;
    localparam int CLASS_W   = 8;
    localparam int ROOT_ADDR = 0;
    localparam int MAX_HOPS  = 32;

    // Node word = {coeff[N_ATTR-1..0], thr}; child word = {L_leaf, L_ptr, R_leaf, R_ptr}
    localparam int NODE_W  = N_ATTR * COEFF_W + THR_W;
    localparam int PTR_W   = ADDR_W + 1;
    localparam int CHILD_W = 2 * PTR_W;
    localparam int PROD_W  = ATTR_W + COEFF_W;
    localparam int ACC_W   = ATTR_W + COEFF_W + $clog2(N_ATTR);
    localparam int HOPS_W  = $clog2(MAX_HOPS + 1);
    localparam int IDX_W   = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
    localparam int RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_MAC    = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [COEFF_W-1:0] f_coeff(input logic [NODE_W-1:0] node,
                                                   input logic [IDX_W-1:0] idx);
        return node[THR_W + int'(idx) * COEFF_W +: COEFF_W];
    endfunction

    function automatic logic [THR_W-1:0] f_thr(input logic [NODE_W-1:0] node);
        return node[THR_W-1:0];
    endfunction

    function automatic logic f_l_leaf(input logic [CHILD_W-1:0] child);
        return child[CHILD_W-1];
    endfunction

    function automatic logic [ADDR_W-1:0] f_l_ptr(input logic [CHILD_W-1:0] child);
        return child[CHILD_W-2 -: ADDR_W];
    endfunction

    function automatic logic f_r_leaf(input logic [CHILD_W-1:0] child);
        return child[ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] f_r_ptr(input logic [CHILD_W-1:0] child);
        return child[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/bdd_traverse_engine_if.sv
// Bus bundle between the attribute/config source and the traversal engine.
// Handshake: a request is start=1 in a cycle where busy=0; it is accepted on
// that clock edge and attr_in is latched. start while busy=1 is ignored, not
// queued. The result is out_valid for exactly one cycle with out_class/err/hops,
// which then hold until the next out_valid. cfg_we is honoured only while busy=0.
interface bdd_traverse_engine_if;
    import bdd_pkg::*;

    logic                     i_cfg_we;
    logic [ADDR_W-1:0]        i_cfg_addr;
    logic [NODE_W-1:0]        i_cfg_node;
    logic [CHILD_W-1:0]       i_cfg_child;
    logic                     i_start;
    logic [N_ATTR*ATTR_W-1:0] i_attr_in;
    logic                     o_busy;
    logic                     o_out_valid;
    logic [CLASS_W-1:0]       o_out_class;
    logic                     o_out_err;
    logic [HOPS_W-1:0]        o_out_hops;
    state_t                   o_dbg_state;

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_node, i_cfg_child, i_start, i_attr_in,
        input  o_busy, o_out_valid, o_out_class, o_out_err, o_out_hops, o_dbg_state
    );

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_node, i_cfg_child, i_start, i_attr_in,
        output o_busy, o_out_valid, o_out_class, o_out_err, o_out_hops, o_dbg_state
    );

endinterface

// File: rtl/bdd_node_ram.sv
// Simple one-write / one-synchronous-read table. Contents survive reset.
module bdd_node_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port and registered read port; a write is visible to reads on later edges.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/bdd_traverse_engine.sv
// Decision-diagram classifier: walks the node table from the root, computing a
// per-node dot product against the latched attributes and following child
// pointers until a leaf class, an out-of-range pointer or the hop limit.
module bdd_traverse_engine
    import bdd_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    bdd_traverse_engine_if.slave bus
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [N_ATTR*ATTR_W-1:0] r_attr;
    logic [RAM_AW-1:0]        r_node;
    logic [IDX_W-1:0]         r_idx;
    logic [ACC_W-1:0]         r_acc;
    logic [HOPS_W-1:0]        r_hops;
    logic [CLASS_W-1:0]       r_class;
    logic                     r_err;
    logic                     r_out_valid;
    logic [CLASS_W-1:0]       r_out_class;
    logic                     r_out_err;
    logic [HOPS_W-1:0]        r_out_hops;

    logic [NODE_W-1:0]        w_node_word;
    logic [CHILD_W-1:0]       w_child_word;
    logic                     w_cfg_wr;
    logic [ATTR_W-1:0]        w_attr;
    logic [COEFF_W-1:0]       w_coeff;
    logic [PROD_W-1:0]        w_prod;
    logic                     w_last_mac;
    logic                     w_take_r;
    logic                     w_leaf;
    logic [ADDR_W-1:0]        w_ptr;
    logic [HOPS_W-1:0]        w_hops_inc;
    logic                     w_bad;

    // Table writes only land while idle and inside the table.
    assign w_cfg_wr = (r_state == S_IDLE) && bus.i_cfg_we && (int'(bus.i_cfg_addr) < DEPTH);

    bdd_node_ram #(.WIDTH(NODE_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_node_ram (
        .i_clk   (i_clk),
        .i_we    (w_cfg_wr),
        .i_waddr (bus.i_cfg_addr[RAM_AW-1:0]),
        .i_wdata (bus.i_cfg_node),
        .i_raddr (r_node),
        .o_rdata (w_node_word)
    );

    bdd_node_ram #(.WIDTH(CHILD_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_child_ram (
        .i_clk   (i_clk),
        .i_we    (w_cfg_wr),
        .i_waddr (bus.i_cfg_addr[RAM_AW-1:0]),
        .i_wdata (bus.i_cfg_child),
        .i_raddr (r_node),
        .o_rdata (w_child_word)
    );

    assign w_attr     = r_attr[int'(r_idx) * ATTR_W +: ATTR_W];
    assign w_coeff    = f_coeff(w_node_word, r_idx);
    assign w_prod     = PROD_W'(w_attr) * PROD_W'(w_coeff);
    assign w_last_mac = (int'(r_idx) == N_ATTR - 1);

    // Branch decision and next-state selection for the walk.
    always_comb begin
        w_take_r    = r_acc > ACC_W'(f_thr(w_node_word));
        w_leaf      = w_take_r ? f_r_leaf(w_child_word) : f_l_leaf(w_child_word);
        w_ptr       = w_take_r ? f_r_ptr(w_child_word) : f_l_ptr(w_child_word);
        w_hops_inc  = r_hops + HOPS_W'(1);
        w_bad       = (int'(w_ptr) >= DEPTH) || (int'(w_hops_inc) >= MAX_HOPS);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.i_start) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_MAC;
            S_MAC:    if (w_last_mac) w_state_nxt = S_DECIDE;
            S_DECIDE: w_state_nxt = (w_leaf || w_bad) ? S_DONE : S_FETCH;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Walk datapath: attribute latch, node pointer, MAC accumulator, hop counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_attr  <= '0;
            r_node  <= RAM_AW'(ROOT_ADDR);
            r_idx   <= '0;
            r_acc   <= '0;
            r_hops  <= '0;
            r_class <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    r_attr <= bus.i_attr_in;
                    r_node <= RAM_AW'(ROOT_ADDR);
                    r_hops <= '0;
                end
                S_FETCH: begin
                    r_acc <= '0;
                    r_idx <= '0;
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_idx <= r_idx + IDX_W'(1);
                end
                S_DECIDE: begin
                    r_hops <= w_hops_inc;
                    if (w_leaf) begin
                        r_class <= w_ptr[CLASS_W-1:0];
                        r_err   <= 1'b0;
                    end else if (w_bad) begin
                        r_class <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_node  <= w_ptr[RAM_AW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: one-cycle valid pulse, payload held until the next result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_err   <= 1'b0;
            r_out_hops  <= '0;
        end else begin
            r_out_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_out_class <= r_class;
                r_out_err   <= r_err;
                r_out_hops  <= r_hops;
            end
        end
    end

    assign bus.o_busy      = (r_state != S_IDLE);
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_out_class = r_out_class;
    assign bus.o_out_err   = r_out_err;
    assign bus.o_out_hops  = r_out_hops;
    assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_bdd_traverse_engine.sv
// Self-checking bench: directed scenarios plus random tables and walks, with a
// queue-based scoreboard fed from a behavioural tree-walk model.
module tb_bdd_traverse_engine;
  import bdd_pkg::*;

  localparam int EXP_W = CLASS_W + 1 + HOPS_W;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  bdd_traverse_engine_if bus();

  bdd_traverse_engine dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model state ----------------
  int m_co [DEPTH][N_ATTR];
  int m_thr [DEPTH];
  int m_ll [DEPTH];
  int m_lp [DEPTH];
  int m_rl [DEPTH];
  int m_rp [DEPTH];
  int cfg_co [N_ATTR];
  int stim_attr [N_ATTR];

  logic [EXP_W-1:0] exp_q[$];
  int               lat_q[$];
  int               acc_q[$];
  logic             prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Walk the tree as described: dot product, compare, follow child.
  function automatic logic [EXP_W-1:0] model_walk(output int hops_o);
    int node, acc, ptr, leaf;
    node = ROOT_ADDR;
    for (int h = 1; h <= MAX_HOPS; h++) begin
      acc = 0;
      for (int i = 0; i < N_ATTR; i++) acc += stim_attr[i] * m_co[node][i];
      if (acc <= m_thr[node]) begin
        leaf = m_ll[node]; ptr = m_lp[node];
      end else begin
        leaf = m_rl[node]; ptr = m_rp[node];
      end
      hops_o = h;
      if (leaf != 0) return {CLASS_W'(ptr), 1'b0, HOPS_W'(h)};
      if (ptr >= DEPTH || h == MAX_HOPS) return {CLASS_W'(0), 1'b1, HOPS_W'(h)};
      node = ptr;
    end
    hops_o = MAX_HOPS;
    return {CLASS_W'(0), 1'b1, HOPS_W'(MAX_HOPS)};
  endfunction

  function automatic void model_set(input int addr, input int thr, input int ll, input int lp,
                                    input int rl, input int rp);
    if (addr < DEPTH) begin
      for (int i = 0; i < N_ATTR; i++) m_co[addr][i] = cfg_co[i];
      m_thr[addr] = thr;
      m_ll[addr] = ll; m_lp[addr] = lp; m_rl[addr] = rl; m_rp[addr] = rp;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int addr, input int thr, input int ll, input int lp,
                         input int rl, input int rp);
    logic [NODE_W-1:0] nw;
    nw = '0;
    nw[THR_W-1:0] = THR_W'(thr);
    for (int i = 0; i < N_ATTR; i++) nw[THR_W + i*COEFF_W +: COEFF_W] = COEFF_W'(cfg_co[i]);
    bus.i_cfg_we    = 1'b1;
    bus.i_cfg_addr  = ADDR_W'(addr);
    bus.i_cfg_node  = nw;
    bus.i_cfg_child = {1'(ll), ADDR_W'(lp), 1'(rl), ADDR_W'(rp)};
  endtask

  task automatic write_node(input int addr, input int thr, input int ll, input int lp,
                            input int rl, input int rp, input bit commit);
    @(negedge clk);
    set_cfg(addr, thr, ll, lp, rl, rp);
    if (commit) model_set(addr, thr, ll, lp, rl, rp);
    @(negedge clk);
    bus.i_cfg_we = 1'b0;
  endtask

  task automatic write_uni(input int addr, input int c, input int thr, input int ll, input int lp,
                           input int rl, input int rp, input bit commit);
    for (int i = 0; i < N_ATTR; i++) cfg_co[i] = c;
    write_node(addr, thr, ll, lp, rl, rp, commit);
  endtask

  task automatic set_attr_all(input int v);
    for (int i = 0; i < N_ATTR; i++) stim_attr[i] = v;
  endtask

  task automatic drive_start();
    logic [N_ATTR*ATTR_W-1:0] v;
    for (int i = 0; i < N_ATTR; i++) v[i*ATTR_W +: ATTR_W] = ATTR_W'(stim_attr[i]);
    bus.i_start   = 1'b1;
    bus.i_attr_in = v;
  endtask

  task automatic finish_start(input bit push);
    int h;
    logic [EXP_W-1:0] e;
    bus.i_start   = 1'b0;
    bus.i_attr_in = $urandom();
    if (push) begin
      e = model_walk(h);
      exp_q.push_back(e);
      lat_q.push_back(h * (N_ATTR + 2) + 1);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic walk(input bit push);
    @(negedge clk);
    drive_start();
    @(negedge clk);
    finish_start(push);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("walk_timeout", exp_q.size(), 0);
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run();
    walk(1'b1);
    wait_done();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    int l, a;
    if (!rst) begin
      if (bus.o_out_valid) begin
        check("valid_pulse_width", prev_valid, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", bus.o_out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          a = acc_q.pop_front();
          check("out_class", bus.o_out_class, e[EXP_W-1 -: CLASS_W]);
          check("out_err", bus.o_out_err, e[HOPS_W]);
          check("out_hops", bus.o_out_hops, e[HOPS_W-1:0]);
          check("latency", cyc - a, l);
        end
      end
      prev_valid = bus.o_out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0; errors = 0; checks = 0; prev_valid = 1'b0;
    rst = 1'b1;
    bus.i_cfg_we = 1'b0; bus.i_cfg_addr = '0; bus.i_cfg_node = '0; bus.i_cfg_child = '0;
    bus.i_start = 1'b0; bus.i_attr_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_out_valid", bus.o_out_valid, 0);
    check("rst_out_class", bus.o_out_class, 0);
    check("rst_out_err", bus.o_out_err, 0);
    check("rst_out_hops", bus.o_out_hops, 0);
    check("rst_state", bus.o_dbg_state, S_IDLE);
    rst = 1'b0;

    // One-node tree: boundary acc == thr goes left, acc == thr+1 goes right
    write_uni(0, 1, 40, 1, 5, 1, 9, 1'b1);
    set_attr_all(10);
    run();
    stim_attr[3] = 11;
    run();

    // Reset in the middle of MAC aborts the walk
    set_attr_all(10);
    walk(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_out_valid", bus.o_out_valid, 0);
    check("midrst_state", bus.o_dbg_state, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run();

    // Two-node walk: root goes right to node 3, node 3 goes left to leaf 0x2A
    write_uni(0, 1, 40, 1, 5, 0, 3, 1'b1);
    write_uni(3, 1, 100, 1, 42, 1, 7, 1'b1);
    set_attr_all(20);
    run();

    // Self loop on the root -> hop limit error
    write_uni(0, 1, 40, 0, 0, 0, 0, 1'b1);
    set_attr_all($urandom_range(0, 255));
    run();

    // Out-of-range child pointer -> error after one hop
    write_uni(0, 1, 40, 0, 40, 0, 40, 1'b1);
    run();

    // Writes to addresses past the table are dropped
    write_uni(0, 1, 40, 1, 5, 0, 8, 1'b1);
    write_uni(8, 0, 0, 1, 17, 1, 34, 1'b1);
    set_attr_all(20);
    run();
    write_uni(40, 0, 0, 1, 102, 1, 103, 1'b1);
    write_uni(255, 7, 0, 0, 99, 0, 99, 1'b1);
    run();

    // Start and cfg_we while busy are both ignored
    write_uni(0, 1, 40, 1, 5, 1, 9, 1'b1);
    set_attr_all(10);
    walk(1'b1);
    check("busy_while_walking", bus.o_busy, 1);
    set_attr_all(200);
    walk(1'b0);
    write_uni(0, 1, 100, 1, 77, 1, 78, 1'b0);
    wait_done();
    set_attr_all(10);
    run();

    // cfg_we and start in the same idle cycle: walk sees the new root word
    set_attr_all(10);
    @(negedge clk);
    for (int i = 0; i < N_ATTR; i++) cfg_co[i] = 1;
    set_cfg(0, 40, 1, 51, 1, 9);
    model_set(0, 40, 1, 51, 1, 9);
    drive_start();
    @(negedge clk);
    bus.i_cfg_we = 1'b0;
    finish_start(1'b1);
    wait_done();

    // Maximum arithmetic: no accumulator wrap, goes right
    write_uni(0, 63, 1023, 1, 1, 1, 2, 1'b1);
    set_attr_all(255);
    run();

    // Random tables and random attribute vectors
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < DEPTH; a++) begin
        int ll, lp, rl, rp;
        for (int i = 0; i < N_ATTR; i++) cfg_co[i] = $urandom_range(0, 63);
        ll = $urandom_range(0, 1);
        rl = $urandom_range(0, 1);
        lp = ll ? $urandom_range(0, 255) : $urandom_range(0, 35);
        rp = rl ? $urandom_range(0, 255) : $urandom_range(0, 35);
        write_node(a, $urandom_range(0, 1023), ll, lp, rl, rp, 1'b1);
      end
      for (int w = 0; w < 15; w++) begin
        for (int i = 0; i < N_ATTR; i++) stim_attr[i] = $urandom_range(0, 255);
        walk(1'b1);
        if ($urandom_range(0, 2) == 0) begin
          for (int i = 0; i < N_ATTR; i++) stim_attr[i] = $urandom_range(0, 255);
          walk(1'b0);
        end
        wait_done();
      end
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
